// File: rtl/seven_seg_scan_ctrl_if.sv
// Digit-pair update channel between a producer and the scan controller.
// The producer offers a new pair with upd_valid. The controller raises
// upd_ready only on the last cycle of a frame.
interface seven_seg_scan_ctrl_if;
  logic       upd_valid;
  logic [3:0] upd_d0;
  logic [3:0] upd_d1;
  logic       upd_ready;

  modport master (
    output upd_valid,
    output upd_d0,
    output upd_d1,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_d0,
    input  upd_d1,
    output upd_ready
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Dual-digit common-anode 7-segment scan controller.
// One BCD decoder is shared between two digits by time-multiplexing:
// BLANK0 -> SHOW0 -> BLANK1 -> SHOW1. Blank slots keep both anodes off,
// which prevents ghosting when the decoder input changes.
// A new digit pair is taken only at the frame boundary, so a frame never
// shows digits from two different pairs.
module seven_seg_scan_ctrl #(
  parameter int DEAD = 2,
  parameter int SHOW = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  seven_seg_scan_ctrl_if.slave      upd,
  output logic [3:0]                dec_s,
  output logic [1:0]                an_n,
  output logic                      frame_tick
);

  localparam int MAXN = (DEAD > SHOW) ? DEAD : SHOW;
  localparam int CW   = $clog2(MAXN + 1);

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW - 1);
  localparam logic [3:0]    BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]    h0_r, h1_r, h0_nxt_s, h1_nxt_s;
  logic [1:0]    an_n_r, an_n_nxt_s;
  logic [3:0]    dec_r, dec_nxt_s;
  logic          ready_pre_r, ready_pre_nxt_s;
  logic          slot_last_s;

  // Last cycle of the current slot. Blank slots last DEAD cycles and
  // display slots last SHOW cycles.
  function automatic logic slot_is_last(input state_t st, input logic [CW-1:0] c);
    logic r;
    case (st)
      BLANK0, BLANK1: r = (c == DEAD_LAST);
      SHOW0, SHOW1:   r = (c == SHOW_LAST);
      default:        r = 1'b1;
    endcase
    return r;
  endfunction

  // Slot-end detection for the current state.
  always_comb begin
    slot_last_s = slot_is_last(state_r, cnt_r);
  end

  // Next-state, slot counter and held-digit capture. Dropping en parks
  // the scan at the start of BLANK0, so re-enabling always begins with a
  // full blank slot.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    h0_nxt_s    = h0_r;
    h1_nxt_s    = h1_r;
    if (!en) begin
      state_nxt_s = BLANK0;
      cnt_nxt_s   = {CW{1'b0}};
    end else if (slot_last_s) begin
      cnt_nxt_s = {CW{1'b0}};
      case (state_r)
        BLANK0: state_nxt_s = SHOW0;
        SHOW0:  state_nxt_s = BLANK1;
        BLANK1: state_nxt_s = SHOW1;
        SHOW1: begin
          state_nxt_s = BLANK0;
          if (upd.upd_valid) begin
            h0_nxt_s = upd.upd_d0;
            h1_nxt_s = upd.upd_d1;
          end else begin
            h0_nxt_s = h0_r;
            h1_nxt_s = h1_r;
          end
        end
        default: state_nxt_s = BLANK0;
      endcase
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // Decode the registered outputs from the next state. The visible
  // outputs then follow state, cnt, h0 and h1 exactly, and they come
  // straight from flops.
  always_comb begin
    an_n_nxt_s      = 2'b11;
    dec_nxt_s       = BLANK_CODE;
    ready_pre_nxt_s = 1'b0;
    case (state_nxt_s)
      BLANK0, BLANK1: begin
        an_n_nxt_s = 2'b11;
        dec_nxt_s  = BLANK_CODE;
      end
      SHOW0: begin
        an_n_nxt_s = 2'b10;
        dec_nxt_s  = h0_nxt_s;
      end
      SHOW1: begin
        an_n_nxt_s = 2'b01;
        dec_nxt_s  = h1_nxt_s;
      end
      default: begin
        an_n_nxt_s = 2'b11;
        dec_nxt_s  = BLANK_CODE;
      end
    endcase
    if ((state_nxt_s == SHOW1) && (cnt_nxt_s == SHOW_LAST)) begin
      ready_pre_nxt_s = 1'b1;
    end else begin
      ready_pre_nxt_s = 1'b0;
    end
  end

  // State register. Reset parks the scan at the start of BLANK0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= BLANK0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Held digits and output flops. The digits reset to the blank code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h0_r        <= BLANK_CODE;
      h1_r        <= BLANK_CODE;
      an_n_r      <= 2'b11;
      dec_r       <= BLANK_CODE;
      ready_pre_r <= 1'b0;
    end else begin
      h0_r        <= h0_nxt_s;
      h1_r        <= h1_nxt_s;
      an_n_r      <= an_n_nxt_s;
      dec_r       <= dec_nxt_s;
      ready_pre_r <= ready_pre_nxt_s;
    end
  end

  // The frame boundary is only offered while scanning is enabled. If en
  // falls on that cycle, the handshake is withdrawn immediately.
  assign upd.upd_ready = en & ready_pre_r;
  assign frame_tick    = en & ready_pre_r;
  assign an_n          = an_n_r;
  assign dec_s         = dec_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl with DEAD=2 and SHOW=4.
// The reference model tracks the position within a 12-cycle frame and
// the two held digits. Expected outputs are derived from those values.
module tb_seven_seg_scan_ctrl;
  localparam int DEAD  = 2;
  localparam int SHOW  = 4;
  localparam int FRAME = 2 * (DEAD + SHOW);

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] dec_s;
  logic [1:0] an_n;
  logic       frame_tick;

  seven_seg_scan_ctrl_if upd_if();

  seven_seg_scan_ctrl #(.DEAD(DEAD), .SHOW(SHOW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .upd        (upd_if),
    .dec_s      (dec_s),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: position within the frame and the held digits.
  int         p;
  logic [3:0] m_h0, m_h1;
  logic [1:0] last_lit;
  int         blank_run;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p         = 0;
    m_h0      = 4'hF;
    m_h1      = 4'hF;
    last_lit  = 2'b11;
    blank_run = 0;
  endtask

  task automatic check_outputs();
    logic [1:0] e_an;
    logic [3:0] e_dec;
    logic       e_rdy;
    if (p < DEAD) begin
      e_an = 2'b11; e_dec = 4'hF;
    end else if (p < DEAD + SHOW) begin
      e_an = 2'b10; e_dec = m_h0;
    end else if (p < 2 * DEAD + SHOW) begin
      e_an = 2'b11; e_dec = 4'hF;
    end else begin
      e_an = 2'b01; e_dec = m_h1;
    end
    e_rdy = en && (p == FRAME - 1);
    chk("an_n", {6'd0, an_n}, {6'd0, e_an});
    chk("dec_s", {4'd0, dec_s}, {4'd0, e_dec});
    chk("upd_ready", {7'd0, upd_if.upd_ready}, {7'd0, e_rdy});
    chk("frame_tick", {7'd0, frame_tick}, {7'd0, e_rdy});
    chk("an_not_00", {7'd0, (an_n === 2'b00)}, 8'd0);
    if (an_n === 2'b11) begin
      blank_run++;
    end else begin
      if ((an_n !== last_lit) && (last_lit !== 2'b11))
        chk("dead_time", {7'd0, (blank_run >= DEAD)}, 8'd1);
      last_lit  = an_n;
      blank_run = 0;
    end
  endtask

  // Called at a falling edge with the inputs already driven. Checks the
  // outputs, then advances the model across the next rising edge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    if (!en) begin
      p = 0;
    end else begin
      if ((p == FRAME - 1) && upd_if.upd_valid) begin
        m_h0 = upd_if.upd_d0;
        m_h1 = upd_if.upd_d1;
      end
      p = (p + 1) % FRAME;
    end
    @(negedge clk);
  endtask

  initial begin
    upd_if.upd_valid = 1'b0;
    upd_if.upd_d0    = 4'h0;
    upd_if.upd_d1    = 4'h0;
    en               = 1'b1;
    reset_n          = 1'b0;
    model_reset();

    // Reset held: blank outputs, no handshake.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_an_n", {6'd0, an_n}, 8'h03);
    chk("rst_dec_s", {4'd0, dec_s}, 8'h0F);
    chk("rst_upd_ready", {7'd0, upd_if.upd_ready}, 8'd0);
    chk("rst_frame_tick", {7'd0, frame_tick}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Free-running scan with no update.
    repeat (2 * FRAME) step();

    // Update held valid from cycle 0. The transfer happens at the frame end.
    upd_if.upd_valid = 1'b1;
    upd_if.upd_d0    = 4'h3;
    upd_if.upd_d1    = 4'h7;
    repeat (FRAME) step();
    upd_if.upd_valid = 1'b0;
    upd_if.upd_d0    = 4'h0;
    upd_if.upd_d1    = 4'h0;
    repeat (2 * FRAME) step();

    // valid pulsed mid-frame: it must be ignored.
    upd_if.upd_d0 = 4'h9;
    upd_if.upd_d1 = 4'h9;
    repeat (FRAME) begin
      upd_if.upd_valid = (p == 5);
      step();
    end
    upd_if.upd_valid = 1'b0;
    repeat (FRAME) step();

    // Enable drop inside SHOW0, then restart from a full blank slot.
    repeat (3) step();
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    repeat (FRAME + 2) step();

    // Asynchronous reset during SHOW1.
    repeat (FRAME) begin
      if (p != 2 * DEAD + SHOW) step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_an_n", {6'd0, an_n}, 8'h03);
    chk("midrst_dec_s", {4'd0, dec_s}, 8'h0F);
    chk("midrst_upd_ready", {7'd0, upd_if.upd_ready}, 8'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * FRAME) step();

    // Random en / upd_valid / data traffic.
    repeat (10000) begin
      en               = ($urandom_range(0, 15) != 0);
      upd_if.upd_valid = $urandom_range(0, 1) == 1;
      upd_if.upd_d0    = 4'($urandom_range(0, 15));
      upd_if.upd_d1    = 4'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
